// File: rtl/spi_regbank_pkg.sv
// spi_regbank_pkg: register map, fast-command codes and busy-timer states
package spi_regbank_pkg;
   localparam logic [2:0] ADDR_ID       = 3'd0;
   localparam logic [2:0] ADDR_CTRL     = 3'd1;
   localparam logic [2:0] ADDR_CFG0     = 3'd2;
   localparam logic [2:0] ADDR_CFG1     = 3'd3;
   localparam logic [2:0] ADDR_IRQ_PEND = 3'd4;
   localparam logic [2:0] ADDR_IRQ_MASK = 3'd5;
   localparam logic [2:0] ADDR_HW_STAT  = 3'd6;
   localparam logic [2:0] ADDR_SCRATCH  = 3'd7;
   localparam logic [5:0] FC_START      = 6'h01;
   localparam logic [5:0] FC_SOFT_RST   = 6'h02;
   localparam logic [5:0] FC_CLR_IRQ    = 6'h03;
   localparam logic [5:0] FC_CLR_ERR    = 6'h04;
   typedef enum logic {ST_IDLE, ST_BUSY} timer_state_e;
endpackage

// File: rtl/spi_regbank_busy_timer.sv
// spi_regbank_busy_timer: START-launched busy window; done is high on the
// cycle whose edge closes the window so the caller can latch it on that edge.
module spi_regbank_busy_timer
   import spi_regbank_pkg::*;
#(
   parameter int BUSY_CYCLES = 16
) (
   input  logic clk,
   input  logic nrst,
   input  logic start,
   input  logic clr,
   output logic busy,
   output logic done
);
   localparam int CW = $clog2(BUSY_CYCLES + 1);
   timer_state_e state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   always_ff @(posedge clk) begin
      if (!nrst) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      done    = 1'b0;
      if (clr) begin
         state_n = ST_IDLE;
         cnt_n   = '0;
      end else if (state == ST_IDLE) begin
         if (start) begin
            state_n = ST_BUSY;
            cnt_n   = CW'(BUSY_CYCLES);
         end
      end else begin
         cnt_n = cnt - CW'(1);
         if (cnt == CW'(1)) begin
            state_n = ST_IDLE;
            done    = 1'b1;
         end
      end
   end
   assign busy = (state == ST_BUSY);
endmodule

// File: rtl/spi_regbank.sv
// spi_regbank: register bank and fast-command sink behind the SPI slave front end
module spi_regbank
   import spi_regbank_pkg::*;
#(
   parameter int         ADDR_W      = 3,
   parameter int         REG_W       = 8,
   parameter logic [7:0] ID_VALUE    = 8'hA5,
   parameter int         BUSY_CYCLES = 16
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic [ADDR_W-1:0] reg_addr,
   input  logic [REG_W-1:0]  reg_wdata,
   input  logic              reg_wdata_vld,
   output logic [REG_W-1:0]  reg_rdata,
   input  logic [5:0]        fastcmd,
   input  logic              fastcmd_vld,
   output logic [7:0]        status,
   input  logic [2:0]        irq_src,
   input  logic [REG_W-1:0]  hw_status,
   output logic [REG_W-1:0]  ctrl_o,
   output logic [REG_W-1:0]  cfg0_o,
   output logic [REG_W-1:0]  cfg1_o,
   output logic              start_pulse,
   output logic              soft_rst,
   output logic              busy,
   output logic              irq
);
   logic [REG_W-1:0] scratch, rdata_n;
   logic [3:0] pend, mask, set, w1c;
   logic [2:0] src_q;
   logic wr_err, cmd_err, done;
   logic fc_start, fc_soft, fc_clr_irq, fc_clr_err, fc_bad, ro_wr;
   assign fc_start   = fastcmd_vld && fastcmd == FC_START;
   assign fc_soft    = fastcmd_vld && fastcmd == FC_SOFT_RST;
   assign fc_clr_irq = fastcmd_vld && fastcmd == FC_CLR_IRQ;
   assign fc_clr_err = fastcmd_vld && fastcmd == FC_CLR_ERR;
   assign fc_bad     = (fastcmd_vld && (fastcmd == 6'h00 || fastcmd > FC_CLR_ERR)) || (fc_start && busy);
   assign ro_wr      = reg_wdata_vld && (reg_addr == ADDR_ID || reg_addr == ADDR_HW_STAT);
   assign w1c        = (reg_wdata_vld && reg_addr == ADDR_IRQ_PEND) ? reg_wdata[3:0] : 4'h0;
   assign set        = {irq_src & ~src_q, done};
   spi_regbank_busy_timer #(.BUSY_CYCLES(BUSY_CYCLES)) u_timer (
      .clk   (clk),
      .nrst  (nrst),
      .start (fc_start),
      .clr   (fc_soft),
      .busy  (busy),
      .done  (done)
   );
   always_comb begin
      rdata_n = '0;
      case (reg_addr)
         ADDR_ID:       rdata_n = ID_VALUE;
         ADDR_CTRL:     rdata_n = ctrl_o;
         ADDR_CFG0:     rdata_n = cfg0_o;
         ADDR_CFG1:     rdata_n = cfg1_o;
         ADDR_IRQ_PEND: rdata_n = {4'h0, pend};
         ADDR_IRQ_MASK: rdata_n = {4'h0, mask};
         ADDR_HW_STAT:  rdata_n = hw_status;
         default:       rdata_n = scratch;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!nrst) begin
         {ctrl_o, cfg0_o, cfg1_o, scratch} <= '0;
         {pend, mask, src_q, wr_err, cmd_err} <= '0;
         {reg_rdata, status, start_pulse, soft_rst, irq} <= '0;
      end else begin
         src_q       <= irq_src;
         reg_rdata   <= rdata_n;
         status      <= {irq, busy, cmd_err, wr_err, pend};
         irq         <= |(pend & mask);
         start_pulse <= fc_start && !busy;
         soft_rst    <= fc_soft;
         if (fc_soft) begin
            {ctrl_o, cfg0_o, cfg1_o, scratch} <= '0;
            {pend, mask, wr_err, cmd_err} <= '0;
         end else begin
            if (reg_wdata_vld && reg_addr == ADDR_CTRL) ctrl_o <= reg_wdata;
            if (reg_wdata_vld && reg_addr == ADDR_CFG0) cfg0_o <= reg_wdata;
            if (reg_wdata_vld && reg_addr == ADDR_CFG1) cfg1_o <= reg_wdata;
            if (reg_wdata_vld && reg_addr == ADDR_SCRATCH) scratch <= reg_wdata;
            if (reg_wdata_vld && reg_addr == ADDR_IRQ_MASK) mask <= reg_wdata[3:0];
            // new events win over both W1C and CLR_IRQ
            pend    <= (pend & ~w1c & {4{!fc_clr_irq}}) | set;
            wr_err  <= ro_wr || (wr_err && !fc_clr_err);
            cmd_err <= fc_bad || (cmd_err && !fc_clr_err);
         end
      end
   end
endmodule

// File: tb/tb_spi_regbank.sv
// tb_spi_regbank: random and directed stimulus against a cycle-level reference model
module tb_spi_regbank;
   localparam int BUSY = 16;
   logic clk = 1'b0, nrst = 1'b0;
   logic [2:0] reg_addr = '0, irq_src = '0;
   logic [7:0] reg_wdata = '0, hw_status = '0, reg_rdata, status, ctrl_o, cfg0_o, cfg1_o;
   logic reg_wdata_vld = 1'b0, fastcmd_vld = 1'b0;
   logic [5:0] fastcmd = '0;
   logic start_pulse, soft_rst, busy, irq;
   int n_tests = 0, n_fail = 0;
   logic [7:0] m_reg [8];
   logic [3:0] m_pend, m_mask;
   logic [2:0] m_srcq;
   logic m_wr_err, m_cmd_err, m_irq, m_start, m_soft;
   logic [7:0] m_rdata, m_status;
   int m_left;
   spi_regbank dut (
      .clk(clk), .nrst(nrst), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
      .reg_wdata_vld(reg_wdata_vld), .reg_rdata(reg_rdata), .fastcmd(fastcmd),
      .fastcmd_vld(fastcmd_vld), .status(status), .irq_src(irq_src),
      .hw_status(hw_status), .ctrl_o(ctrl_o), .cfg0_o(cfg0_o), .cfg1_o(cfg1_o),
      .start_pulse(start_pulse), .soft_rst(soft_rst), .busy(busy), .irq(irq)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic model_edge();
      logic [3:0] set;
      logic busy_now, fin;
      if (!nrst) begin
         foreach (m_reg[i]) m_reg[i] = '0;
         {m_pend, m_mask, m_srcq, m_wr_err, m_cmd_err, m_irq, m_start, m_soft} = '0;
         {m_rdata, m_status} = '0;
         m_left = 0;
         return;
      end
      busy_now = m_left > 0;
      case (reg_addr)
         3'd0: m_rdata = 8'hA5;
         3'd4: m_rdata = {4'h0, m_pend};
         3'd5: m_rdata = {4'h0, m_mask};
         3'd6: m_rdata = hw_status;
         default: m_rdata = m_reg[reg_addr];
      endcase
      m_status = {m_irq, busy_now, m_cmd_err, m_wr_err, m_pend};
      m_irq = |(m_pend & m_mask);
      fin = 1'b0;
      if (busy_now) begin
         m_left--;
         fin = (m_left == 0);
      end
      set = {irq_src & ~m_srcq, fin};
      m_srcq = irq_src;
      m_start = fastcmd_vld && fastcmd == 6'h01 && !busy_now;
      m_soft = fastcmd_vld && fastcmd == 6'h02;
      if (m_start) m_left = BUSY;
      if (m_soft) begin
         foreach (m_reg[i]) m_reg[i] = '0;
         {m_pend, m_mask, m_wr_err, m_cmd_err} = '0;
         m_left = 0;
         return;
      end
      if (fastcmd_vld) begin
         if (fastcmd == 6'h03) m_pend = 4'h0;
         else if (fastcmd == 6'h04) {m_wr_err, m_cmd_err} = 2'b00;
         else if (fastcmd == 6'h01) m_cmd_err = m_cmd_err | busy_now;
         else m_cmd_err = 1'b1;
      end
      if (reg_wdata_vld)
         case (reg_addr)
            3'd1, 3'd2, 3'd3, 3'd7: m_reg[reg_addr] = reg_wdata;
            3'd4: m_pend = m_pend & ~reg_wdata[3:0];
            3'd5: m_mask = reg_wdata[3:0];
            default: m_wr_err = 1'b1;
         endcase
      m_pend = m_pend | set;
   endtask
   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      chk("rdata", reg_rdata, m_rdata);
      chk("status", status, m_status);
      chk("irq", irq, m_irq);
      chk("busy", busy, m_left > 0);
      chk("start_pulse", start_pulse, m_start);
      chk("soft_rst", soft_rst, m_soft);
      chk("ctrl", ctrl_o, m_reg[1]);
      chk("cfg0", cfg0_o, m_reg[2]);
      chk("cfg1", cfg1_o, m_reg[3]);
   endtask
   task automatic idle(input int n);
      repeat (n) step();
   endtask
   task automatic wr(input logic [2:0] a, input logic [7:0] d);
      reg_addr = a;
      reg_wdata = d;
      reg_wdata_vld = 1'b1;
      step();
      reg_wdata_vld = 1'b0;
   endtask
   task automatic fc(input logic [5:0] c);
      fastcmd = c;
      fastcmd_vld = 1'b1;
      step();
      fastcmd_vld = 1'b0;
   endtask
   initial begin
      int n;
      idle(2);
      nrst = 1'b1;
      idle(1);
      chk("id_read", reg_rdata, 8'hA5);
      chk("status_rst", status, 8'h00);
      chk("outs_rst", {start_pulse, soft_rst, busy, irq}, 4'h0);
      wr(3'd2, 8'h3C);
      idle(1);
      chk("cfg0_rdback", reg_rdata, 8'h3C);
      chk("cfg0_o", cfg0_o, 8'h3C);
      wr(3'd6, 8'h55);
      idle(1);
      chk("wr_err_set", status[4], 1'b1);
      fc(6'h04);
      idle(1);
      chk("wr_err_clr", status[4], 1'b0);
      wr(3'd5, 8'h0F);
      irq_src = 3'b010;
      step();
      irq_src = 3'b000;
      idle(3);
      chk("irq_status", status, 8'h84);
      chk("irq_out", irq, 1'b1);
      reg_addr = 3'd4;
      reg_wdata = 8'h04;
      reg_wdata_vld = 1'b1;
      irq_src = 3'b010;
      step();
      reg_wdata_vld = 1'b0;
      irq_src = 3'b000;
      idle(2);
      chk("set_beats_w1c", reg_rdata[2], 1'b1);
      wr(3'd4, 8'h0F);
      idle(2);
      fc(6'h01);
      chk("start_pulse_dir", start_pulse, 1'b1);
      n = 1;
      for (int i = 0; i < 40 && busy; i++) begin
         if (i == 4) begin
            fastcmd = 6'h01;
            fastcmd_vld = 1'b1;
         end
         step();
         fastcmd_vld = 1'b0;
         if (busy) n++;
      end
      chk("busy_len", n, BUSY);
      idle(1);
      chk("pend0_on_fall", status[0], 1'b1);
      chk("cmd_err_busy", status[5], 1'b1);
      fc(6'h04);
      wr(3'd1, 8'hFF);
      wr(3'd5, 8'h0F);
      fc(6'h02);
      chk("soft_pulse", soft_rst, 1'b1);
      chk("soft_ctrl", ctrl_o, 8'h00);
      reg_addr = 3'd0;
      idle(2);
      chk("soft_irq", irq, 1'b0);
      chk("soft_id", reg_rdata, 8'hA5);
      chk("soft_status", status, 8'h00);
      fc(6'h3F);
      idle(1);
      chk("bad_cmd", status[5], 1'b1);
      fc(6'h04);
      fc(6'h01);
      idle(5);
      nrst = 1'b0;
      step();
      chk("rst_abort", busy, 1'b0);
      nrst = 1'b1;
      idle(20);
      chk("rst_no_pend0", status[0], 1'b0);
      for (int i = 0; i < 3000; i++) begin
         nrst = ($urandom % 300) != 0;
         reg_addr = 3'($urandom);
         reg_wdata = 8'($urandom);
         reg_wdata_vld = ($urandom % 3) == 0;
         hw_status = 8'($urandom);
         if ($urandom % 4 == 0) irq_src = 3'($urandom);
         fastcmd_vld = ($urandom % 6) == 0;
         case ($urandom % 10)
            0, 1, 2, 3: fastcmd = 6'h01;
            4: fastcmd = ($urandom % 4 == 0) ? 6'h02 : 6'h01;
            5: fastcmd = 6'h03;
            6: fastcmd = 6'h04;
            default: fastcmd = 6'($urandom);
         endcase
         step();
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/spi_regbank.md
Name: spi_regbank

Overview:
- Register bank and command sink directly downstream of the SPI register-slave front end.
- Consumes its register address, write-data strobe and fast-command strobe; returns read data and the 8-bit status byte shifted out at frame start.
- Holds control/config registers, interrupt pending/mask logic and a START-launched busy timer that drive the user core.

Parameters:
- ADDR_W, 3, register address width (8 registers).
- REG_W, 8, register data width; must be 8.
- ID_VALUE, 8'hA5, constant returned at address 0.
- BUSY_CYCLES, 16, busy-window length after START; must be ≥1.

Ports:
- clk  in  1  system clock.
- nrst  in  1  synchronous active-low reset, sampled on rising clk.
- reg_addr  in  ADDR_W  register address from the SPI front end.
- reg_wdata  in  REG_W  write data from the SPI front end.
- reg_wdata_vld  in  1  one-cycle write strobe.
- reg_rdata  out  REG_W  registered read data for reg_addr.
- fastcmd  in  6  fast-command code.
- fastcmd_vld  in  1  one-cycle fast-command strobe.
- status  out  8  status byte to the SPI front end.
- irq_src  in  3  external event inputs, synchronous to clk.
- hw_status  in  REG_W  core status, readable at address 6.
- ctrl_o, cfg0_o, cfg1_o  out  REG_W each  RW register contents.
- start_pulse  out  1  one-cycle START pulse.
- soft_rst  out  1  one-cycle soft-reset pulse to the core.
- busy  out  1  high during the busy window.
- irq  out  1  registered OR of pend & mask.

Behaviour:
- Map: 0 ID (RO); 1 CTRL; 2 CFG0; 3 CFG1; 4 IRQ_PEND (W1C, bits[3:0]); 5 IRQ_MASK (bits[3:0]); 6 HW_STAT (RO); 7 SCRATCH. Addresses 1, 2, 3, 5, 7 are RW.
- Reset (nrst=0 at clk edge): all registers 0, pend 0, mask 0, wr_err 0, cmd_err 0, busy counter 0, irq_src history 0. Outputs reg_rdata, status, start_pulse, soft_rst, busy, irq all 0.
- Read: reg_rdata <= mux(reg_addr) every cycle, so latency is 1 clk. Unimplemented bits read 0. A write is visible on reg_rdata 2 cycles after the strobe.
- Write on reg_wdata_vld:
  - RW address: register <= reg_wdata.
  - IRQ_PEND: pend &= ~reg_wdata[3:0].
  - RO address (0 or 6): data dropped, wr_err <= 1 (sticky).
- Interrupt pending:
  - pend[3:1] set on a rising edge of irq_src[2:0], detected against the registered previous value.
  - pend[0] set when the busy window ends.
  - Set and W1C clear in the same cycle: set wins.
- Fastcmd on fastcmd_vld:
  - 0x01 START: if idle, start_pulse=1 next cycle, busy=1 next cycle, counter loads BUSY_CYCLES. If busy, cmd_err <= 1 and the command is ignored.
  - 0x02 SOFT_RESET: next cycle all RW registers, pend, mask, wr_err, cmd_err and the busy counter clear; soft_rst=1 for one cycle. ID and the irq_src history are unaffected.
  - 0x03 CLR_IRQ: pend <= 0.
  - 0x04 CLR_ERR: wr_err, cmd_err <= 0.
  - Any other code: cmd_err <= 1.
- Priority when fastcmd_vld and reg_wdata_vld coincide: SOFT_RESET and CLR_IRQ override the write to the affected bits; all other combinations apply both.
- Busy timer:
  - Two states, IDLE and BUSY; the counter decrements each cycle in BUSY.
  - busy is high for exactly BUSY_CYCLES cycles.
  - On the cycle the counter reaches 0: return to IDLE, busy=0 and pend[0]=1 on that same edge.
- irq <= |(pend & mask): 1 cycle after the pend/mask change.
- status <= {irq, busy, cmd_err, wr_err, pend[3:0]}: registered, 1-cycle latency.
- nrst low mid-busy aborts the window and does not set pend[0].

Decomposition:
- Package spi_regbank_pkg holds:
  - register address localparams (ADDR_ID..ADDR_SCRATCH);
  - fastcmd code localparams (FC_START, FC_SOFT_RST, FC_CLR_IRQ, FC_CLR_ERR);
  - busy-timer state enum {ST_IDLE, ST_BUSY}.
- One sub-module: spi_regbank_busy_timer (counter, busy flag, done pulse).

Test Plan:
- Reset, then read addr 0 → reg_rdata=8'hA5 after 1 clk; status=8'h00; all outputs 0.
- Write 8'h3C to addr 2, read back → cfg0_o=8'h3C and reg_rdata=8'h3C two cycles after strobe. Write addr 6 → HW_STAT unchanged, status[4]=1. Fastcmd 0x04 → status[4]=0.
- Mask=4'hF; pulse irq_src[1] → pend=4'b0100, irq=1, status=8'h84. W1C 8'h04 coinciding with a new irq_src[1] edge → pend[2] stays 1.
- Fastcmd 0x01 → start_pulse 1 cycle, busy high exactly 16 cycles, pend[0]=1 on the busy fall. Second 0x01 mid-window → status[5]=1, busy length unchanged.
- Set ctrl=8'hFF, mask=4'hF, pend≠0, then fastcmd 0x02 → soft_rst pulse, ctrl_o=0, pend=0, irq=0; reg_rdata at addr 0 still 8'hA5. Fastcmd 0x3F → status[5]=1.
- Assert nrst low during busy → busy=0 next edge, pend[0]=0 after release.
